z80_irq_sched: RTL and testbench

- Interrupt scheduler for the Z80 cores; one instance per CPU.
- Main CPU: converts the video VBLANK into a maskable INT request.
- Sound CPU: converts sound-latch writes into queued NMI requests.
- Drives intreq/nmireq into the Z80 wrapper and consumes its intack/nmiack decodes (fetch at 0x0038 / 0x0066), so each event is delivered exactly once.

---
 rtl/z80_irq_pkg.sv | 30 +++
 rtl/z80_nmi_queue.sv | 76 +++++++
 rtl/z80_irq_sched.sv | 125 ++++++++++++
 tb/tb_z80_irq_sched.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/z80_irq_pkg.sv
// Shared types and constants for the Z80 interrupt scheduler (z80_irq_sched).
// Optional status word is built only when Z80_IRQ_STATUS_EN is defined.
package z80_irq_pkg;

  typedef enum logic {
    I_IDLE   = 1'b0,
    I_ASSERT = 1'b1
  } int_state_e;

  typedef enum logic [1:0] {
    N_IDLE   = 2'd0,
    N_ASSERT = 2'd1,
    N_GAP    = 2'd2
  } nmi_state_e;

  // irq_status bit positions
  localparam int STAT_EN_BIT   = 0;
  localparam int STAT_PEND_LSB = 1;
  localparam int STAT_OVF_BIT  = 3;
  localparam int STAT_MISS_LSB = 4;

  localparam int DEF_IRQ_HOLD     = 4096;
  localparam int DEF_NMI_GAP      = 16;
  localparam int DEF_NMI_QDEPTH_W = 2;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/z80_nmi_queue.sv
// Saturating NMI pending counter plus NMI request FSM with a mandatory low gap,
// so every queued sound command reaches the Z80 as a separate falling edge.
module z80_nmi_queue
  import z80_irq_pkg::*;
#(
  parameter int NMI_GAP  = DEF_NMI_GAP,
  parameter int QDEPTH_W = DEF_NMI_QDEPTH_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                nmi_trig,
  input  logic                nmiack,
  output logic                nmireq,
  output logic [QDEPTH_W-1:0] pend_count,
  output logic                ovf_pulse
);

  localparam int GW = (NMI_GAP > 1) ? $clog2(NMI_GAP) : 1;
  localparam logic [GW-1:0]       GAP_LAST = GW'(NMI_GAP - 1);
  localparam logic [QDEPTH_W-1:0] CNT_MAX  = '1;

  nmi_state_e          state_q, state_d;
  logic [QDEPTH_W-1:0] count_q, count_d;
  logic [GW-1:0]       gap_q, gap_d;
  logic                deq;

  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    count_d   = count_q;
    deq       = 1'b0;
    ovf_pulse = 1'b0;

    case (state_q)
      N_IDLE: begin
        if (count_q != '0) state_d = N_ASSERT;
      end
      N_ASSERT: begin
        if (nmiack) begin
          state_d = N_GAP;
          gap_d   = '0;
          deq     = 1'b1;
        end
      end
      N_GAP: begin
        if (gap_q == GAP_LAST) state_d = N_IDLE;
        else                   gap_d   = gap_q + GW'(1);
      end
      default: state_d = N_IDLE;
    endcase

    // A trigger and a dequeue in the same cycle cancel out
    if (nmi_trig && !deq) begin
      if (count_q == CNT_MAX) ovf_pulse = 1'b1;
      else                    count_d   = count_q + QDEPTH_W'(1);
    end else if (!nmi_trig && deq) begin
      count_d = count_q - QDEPTH_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= N_IDLE;
      count_q <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      gap_q   <= gap_d;
    end
  end

  assign nmireq     = (state_q == N_ASSERT);
  assign pend_count = count_q;

endmodule

// File: rtl/z80_irq_sched.sv
// Per-CPU Z80 interrupt scheduler: VBLANK rise -> INT with hold timeout, sound
// latch -> queued NMI. Define Z80_IRQ_STATUS_EN to build the irq_status counters.
module z80_irq_sched
  import z80_irq_pkg::*;
#(
  parameter int IRQ_HOLD     = DEF_IRQ_HOLD,
  parameter int NMI_GAP      = DEF_NMI_GAP,
  parameter int NMI_QDEPTH_W = DEF_NMI_QDEPTH_W
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vblank,
  input  logic       irq_en_wr,
  input  logic       irq_en_din,
  input  logic       nmi_trig,
  input  logic       intack,
  input  logic       nmiack,
  output logic       intreq,
  output logic       nmireq,
  output logic [7:0] irq_status
);

  localparam int HW = $clog2(IRQ_HOLD);
  localparam logic [HW-1:0] HOLD_LAST = HW'(IRQ_HOLD - 1);

  int_state_e              int_state_q, int_state_d;
  logic [HW-1:0]           hold_q, hold_d;
  logic                    vblank_d_q;
  logic                    irq_en_q, irq_en_d;
  logic                    rise;
  logic                    missed_evt;
  logic [NMI_QDEPTH_W-1:0] pend_count;
  logic                    nmi_ovf;

  assign rise = vblank & ~vblank_d_q;

  always_comb begin
    int_state_d = int_state_q;
    hold_d      = hold_q;
    missed_evt  = 1'b0;
    irq_en_d    = irq_en_wr ? irq_en_din : irq_en_q;

    case (int_state_q)
      I_IDLE: begin
        // irq_en_q is the pre-write value, so a coincident write does not gate this rise
        if (rise && irq_en_q) begin
          int_state_d = I_ASSERT;
          hold_d      = '0;
        end
      end
      I_ASSERT: begin
        if (intack || (irq_en_wr && !irq_en_din)) begin
          int_state_d = I_IDLE;
        end else if (hold_q == HOLD_LAST) begin
          int_state_d = I_IDLE;
          missed_evt  = 1'b1;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: int_state_d = I_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      int_state_q <= I_IDLE;
      hold_q      <= '0;
      vblank_d_q  <= 1'b0;
      irq_en_q    <= 1'b0;
    end else begin
      int_state_q <= int_state_d;
      hold_q      <= hold_d;
      vblank_d_q  <= vblank;
      irq_en_q    <= irq_en_d;
    end
  end

  assign intreq = (int_state_q == I_ASSERT);

  z80_nmi_queue #(
    .NMI_GAP  (NMI_GAP),
    .QDEPTH_W (NMI_QDEPTH_W)
  ) u_nmi_queue (
    .clk        (clk),
    .reset      (reset),
    .nmi_trig   (nmi_trig),
    .nmiack     (nmiack),
    .nmireq     (nmireq),
    .pend_count (pend_count),
    .ovf_pulse  (nmi_ovf)
  );

`ifdef Z80_IRQ_STATUS_EN
  logic [3:0]              missed_q, missed_d;
  logic                    ovf_sticky_q, ovf_sticky_d;
  logic [NMI_QDEPTH_W+1:0] pend_ext;

  always_comb begin
    missed_d     = missed_evt ? sat_inc4(missed_q) : missed_q;
    ovf_sticky_d = ovf_sticky_q | nmi_ovf;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      missed_q     <= '0;
      ovf_sticky_q <= 1'b0;
    end else begin
      missed_q     <= missed_d;
      ovf_sticky_q <= ovf_sticky_d;
    end
  end

  assign pend_ext = {2'b00, pend_count};
  assign irq_status[STAT_MISS_LSB +: 4] = missed_q;
  assign irq_status[STAT_OVF_BIT]       = ovf_sticky_q;
  assign irq_status[STAT_PEND_LSB +: 2] = pend_ext[1:0];
  assign irq_status[STAT_EN_BIT]        = irq_en_q;
`else
  logic unused_status;
  assign unused_status = ^{missed_evt, nmi_ovf, pend_count};
  assign irq_status    = 8'h00;
`endif

endmodule

// File: tb/tb_z80_irq_sched.sv
// Bench for z80_irq_sched: directed vector table, corner-case sequences and
// randomized traffic checked against a rule-level reference model.
module tb_z80_irq_sched;

  localparam int HOLD = 8;
  localparam int GAP  = 16;
  localparam int QW   = 2;
  localparam int QMAX = 3;

  logic       clk = 1'b0;
  logic       reset, vblank, irq_en_wr, irq_en_din, nmi_trig, intack, nmiack;
  logic       intreq, nmireq;
  logic [7:0] irq_status;

  always #5 clk = ~clk;

  z80_irq_sched #(
    .IRQ_HOLD     (HOLD),
    .NMI_GAP      (GAP),
    .NMI_QDEPTH_W (QW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .vblank     (vblank),
    .irq_en_wr  (irq_en_wr),
    .irq_en_din (irq_en_din),
    .nmi_trig   (nmi_trig),
    .intack     (intack),
    .nmiack     (nmiack),
    .intreq     (intreq),
    .nmireq     (nmireq),
    .irq_status (irq_status)
  );

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference model: INT is "on" until ack, disable or HOLD cycles elapse;
  // NMI is "on" until ack, then a cooldown of GAP cycles must pass before the
  // next pending event can raise it again.
  int m_vb_prev, m_en, m_int_on, m_age, m_missed, m_pend, m_ovf, m_nmi_on, m_cool;

  always @(posedge clk) begin : ref_model
    int rise, deq, n_int_on, n_age, n_missed, n_pend, n_ovf, n_nmi_on, n_cool;
    if (reset) begin
      m_vb_prev <= 0; m_en <= 0; m_int_on <= 0; m_age <= 0; m_missed <= 0;
      m_pend <= 0; m_ovf <= 0; m_nmi_on <= 0; m_cool <= 0;
    end else begin
      rise     = (vblank && m_vb_prev == 0) ? 1 : 0;
      n_int_on = m_int_on;
      n_age    = m_age;
      n_missed = m_missed;
      if (m_int_on != 0) begin
        if (intack || (irq_en_wr && !irq_en_din)) n_int_on = 0;
        else if (m_age == HOLD - 1) begin
          n_int_on = 0;
          if (m_missed < 15) n_missed = m_missed + 1;
        end else n_age = m_age + 1;
      end else if (rise != 0 && m_en != 0) begin
        n_int_on = 1;
        n_age    = 0;
      end

      deq      = (m_nmi_on != 0 && nmiack) ? 1 : 0;
      n_nmi_on = m_nmi_on;
      n_cool   = m_cool;
      if (m_nmi_on != 0) begin
        if (nmiack) begin
          n_nmi_on = 0;
          n_cool   = GAP;
        end
      end else if (m_cool > 0) n_cool = m_cool - 1;
      else if (m_pend > 0) n_nmi_on = 1;

      n_pend = m_pend;
      n_ovf  = m_ovf;
      if (nmi_trig && deq == 0) begin
        if (m_pend == QMAX) n_ovf = 1;
        else n_pend = m_pend + 1;
      end else if (!nmi_trig && deq != 0) n_pend = m_pend - 1;

      m_vb_prev <= vblank ? 1 : 0;
      m_en      <= irq_en_wr ? (irq_en_din ? 1 : 0) : m_en;
      m_int_on  <= n_int_on;
      m_age     <= n_age;
      m_missed  <= n_missed;
      m_pend    <= n_pend;
      m_ovf     <= n_ovf;
      m_nmi_on  <= n_nmi_on;
      m_cool    <= n_cool;
    end
  end

  function automatic int exp_status();
`ifdef Z80_IRQ_STATUS_EN
    return {m_missed[3:0], m_ovf[0], m_pend[1:0], m_en[0]};
`else
    return 0;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    vblank = 0; irq_en_wr = 0; irq_en_din = 0; nmi_trig = 0; intack = 0; nmiack = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    step();
    reset = 0;
  endtask

  // Raise ntrig sound triggers, then ack each NMI (3-cycle ack, 2 cycles in)
  task automatic nmi_run(input string tag, input int ntrig, input int exp_pulses,
                         input int exp_mid_status, input int exp_end_status);
    int pulses, hi_cnt, ack_left, low_run, min_low, prev;
    do_reset();
    for (int i = 0; i < ntrig; i++) begin
      nmi_trig = 1;
      step();
    end
    nmi_trig = 0;
    if (exp_mid_status >= 0) begin
      check({tag, "_sat_status"}, irq_status, exp_mid_status);
      check({tag, "_held"}, nmireq, 1);
    end
    pulses = 0; hi_cnt = 0; ack_left = 0; low_run = 0; min_low = 1000; prev = nmireq;
    if (nmireq) pulses = 1;
    for (int c = 0; c < 600; c++) begin
      if (nmireq) begin
        hi_cnt++;
        if (hi_cnt == 2) ack_left = 3;
      end else hi_cnt = 0;
      nmiack = (ack_left > 0);
      if (ack_left > 0) ack_left--;
      step();
      if (nmireq && prev == 0) begin
        pulses++;
        if (low_run < min_low) min_low = low_run;
      end
      low_run = nmireq ? 0 : low_run + 1;
      prev = nmireq;
    end
    nmiack = 0;
    check({tag, "_pulses"}, pulses, exp_pulses);
    check({tag, "_gap_ge_min"}, (min_low >= GAP) ? 1 : 0, 1);
    check({tag, "_end_req"}, nmireq, 0);
    check({tag, "_end_status"}, irq_status, exp_end_status);
  endtask

  typedef struct {
    logic vb, wr, din, trig, ack_i, ack_n;
    logic e_int, e_nmi;
  } vec_t;

  vec_t vt[18];

  initial begin
    int hi, nmi_seen;
    clear_inputs();
    reset = 1;
    repeat (3) step();
    check("reset_intreq", intreq, 0);
    check("reset_nmireq", nmireq, 0);
    check("reset_status", irq_status, 0);
    reset = 0;

    //          vb    wr    din   trig  ack_i ack_n int   nmi
    vt[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[14] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[17] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    foreach (vt[i]) begin
      vblank = vt[i].vb; irq_en_wr = vt[i].wr; irq_en_din = vt[i].din;
      nmi_trig = vt[i].trig; intack = vt[i].ack_i; nmiack = vt[i].ack_n;
      step();
      check($sformatf("vec%0d_intreq", i), intreq, vt[i].e_int);
      check($sformatf("vec%0d_nmireq", i), nmireq, vt[i].e_nmi);
    end

    // INT hold timeout: exactly HOLD cycles high, one missed event recorded
    do_reset();
    irq_en_wr = 1; irq_en_din = 1;
    step();
    irq_en_wr = 0; vblank = 1;
    step();
    hi = 0;
    for (int i = 0; i < 40 && intreq; i++) begin
      hi++;
      step();
    end
    check("hold_len", hi, HOLD);
    check("hold_dropped", intreq, 0);
`ifdef Z80_IRQ_STATUS_EN
    check("hold_status", irq_status, 8'h11);
`else
    check("hold_status", irq_status, 0);
`endif

    // NMI queue: 3 queued events, then 5 with saturation at 3
`ifdef Z80_IRQ_STATUS_EN
    nmi_run("nmi3", 3, 3, -1, 8'h00);
    nmi_run("nmi5", 5, 3, 8'h0E, 8'h08);
`else
    nmi_run("nmi3", 3, 3, -1, 0);
    nmi_run("nmi5", 5, 3, 0, 0);
`endif

    // Reset while both requests are active
    do_reset();
    irq_en_wr = 1; irq_en_din = 1;
    step();
    irq_en_wr = 0; vblank = 1; nmi_trig = 1;
    step();
    nmi_trig = 0;
    step();
    check("pre_rst_intreq", intreq, 1);
    check("pre_rst_nmireq", nmireq, 1);
    reset = 1;
    step();
    check("rst_intreq", intreq, 0);
    check("rst_nmireq", nmireq, 0);
    check("rst_status", irq_status, 0);
    reset = 0; vblank = 0;
    nmi_seen = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (nmireq) nmi_seen++;
    end
    check("post_rst_no_nmi", nmi_seen, 0);

    // Randomized traffic against the reference model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0) vblank = ~vblank;
      irq_en_wr  = ($urandom_range(0, 59) == 0);
      irq_en_din = ($urandom_range(0, 3) != 0);
      nmi_trig   = ($urandom_range(0, 29) == 0);
      intack     = ($urandom_range(0, 3) == 0);
      nmiack     = ($urandom_range(0, 3) == 0);
      reset      = ($urandom_range(0, 799) == 0);
      step();
      check($sformatf("rnd%0d_intreq", i), intreq, m_int_on);
      check($sformatf("rnd%0d_nmireq", i), nmireq, m_nmi_on);
      check($sformatf("rnd%0d_status", i), irq_status, exp_status());
    end
    clear_inputs();
    reset = 0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
